// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates hit/wall/goal requests onto one square-wave speaker pin
// with fixed priority, preemption, a one-deep pending bit per class and a gap between bursts.
module sfx_scheduler #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned HIT_HALF  = 50000,
  parameter int unsigned WALL_HALF = 100000,
  parameter int unsigned GOAL_HALF = 25000,
  parameter int unsigned HIT_MS    = 40,
  parameter int unsigned WALL_MS   = 30,
  parameter int unsigned GOAL_MS   = 400,
  parameter int unsigned GAP_MS    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [1:0] active
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPlay = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [1:0] ClsNone = 2'd0;
  localparam logic [1:0] ClsHit  = 2'd1;
  localparam logic [1:0] ClsWall = 2'd2;
  localparam logic [1:0] ClsGoal = 2'd3;

  localparam int unsigned HalfHw  = (HIT_HALF > WALL_HALF) ? HIT_HALF : WALL_HALF;
  localparam int unsigned HalfMax = (HalfHw > GOAL_HALF) ? HalfHw : GOAL_HALF;
  localparam int unsigned PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HalfW   = (HalfMax > 1) ? $clog2(HalfMax) : 1;
  localparam int unsigned DurW    = 10;

  localparam logic [PreW-1:0] PreLoad = PreW'(TICK_DIV - 1);
  localparam logic [DurW-1:0] GapLoad = DurW'(GAP_MS - 1);

  // Pending / request vectors are indexed {goal, wall, hit}.
  function automatic logic [2:0] cls_mask(input logic [1:0] c);
    logic [2:0] m;
    case (c)
      ClsHit:  m = 3'b001;
      ClsWall: m = 3'b010;
      ClsGoal: m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] top_class(input logic [2:0] v);
    logic [1:0] c;
    if (v[2])      c = ClsGoal;
    else if (v[1]) c = ClsWall;
    else if (v[0]) c = ClsHit;
    else           c = ClsNone;
    return c;
  endfunction

  function automatic logic [HalfW-1:0] half_load(input logic [1:0] c);
    logic [HalfW-1:0] v;
    case (c)
      ClsHit:  v = HalfW'(HIT_HALF - 1);
      ClsWall: v = HalfW'(WALL_HALF - 1);
      ClsGoal: v = HalfW'(GOAL_HALF - 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [DurW-1:0] dur_load(input logic [1:0] c);
    logic [DurW-1:0] v;
    case (c)
      ClsHit:  v = DurW'(HIT_MS - 1);
      ClsWall: v = DurW'(WALL_MS - 1);
      ClsGoal: v = DurW'(GOAL_MS - 1);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic             hit_q, wall_q, goal_q;
  logic [1:0]       state_q, state_d;
  logic [1:0]       active_q, active_d;
  logic             tone_q, tone_d;
  logic [2:0]       pend_q, pend_d;
  logic [HalfW-1:0] half_q, half_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [DurW-1:0]  dur_q, dur_d;

  logic [2:0] req;
  logic [1:0] req_top;
  logic [1:0] cand;
  logic [1:0] start_cls;
  logic       start;
  logic       tick_end;

  assign req = {goal & ~goal_q, wall & ~wall_q, hit & ~hit_q};

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    tone_d    = tone_q;
    pend_d    = pend_q;
    half_d    = half_q;
    pre_d     = pre_q;
    dur_d     = dur_q;
    start     = 1'b0;
    start_cls = ClsNone;
    req_top   = top_class(req);
    cand      = top_class(pend_q | req);
    tick_end  = (pre_q == '0) && (dur_q == '0);

    unique case (state_q)
      StIdle: begin
        if (cand != ClsNone) begin
          start     = 1'b1;
          start_cls = cand;
        end
      end

      StPlay: begin
        if (req_top > active_q) begin
          start     = 1'b1;
          start_cls = req_top;
        end else begin
          pend_d = pend_q | (req & ~cls_mask(active_q));
          if ((req & cls_mask(active_q)) != 3'b000) begin
            // Retrigger: restart the burst from a clean tone phase.
            tone_d = 1'b0;
            half_d = half_load(active_q);
            pre_d  = PreLoad;
            dur_d  = dur_load(active_q);
          end else if (tick_end) begin
            active_d = ClsNone;
            tone_d   = 1'b0;
            if (pend_d != 3'b000) begin
              state_d = StGap;
              pre_d   = PreLoad;
              dur_d   = GapLoad;
            end else begin
              state_d = StIdle;
            end
          end else begin
            if (half_q == '0) begin
              half_d = half_load(active_q);
              tone_d = ~tone_q;
            end else begin
              half_d = half_q - 1'b1;
            end
            if (pre_q == '0) begin
              pre_d = PreLoad;
              dur_d = dur_q - 1'b1;
            end else begin
              pre_d = pre_q - 1'b1;
            end
          end
        end
      end

      StGap: begin
        if (req[2]) begin
          start     = 1'b1;
          start_cls = ClsGoal;
        end else begin
          pend_d = pend_q | req;
          if (tick_end) begin
            state_d = StIdle;
          end else if (pre_q == '0) begin
            pre_d = PreLoad;
            dur_d = dur_q - 1'b1;
          end else begin
            pre_d = pre_q - 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Losing requests are pended; a goal start wipes stale rally sounds.
    if (start) begin
      pend_d = (pend_q | req) & ~cls_mask(start_cls);
      if (start_cls == ClsGoal) begin
        pend_d[1:0] = 2'b00;
      end
      state_d  = StPlay;
      active_d = start_cls;
      tone_d   = 1'b0;
      half_d   = half_load(start_cls);
      pre_d    = PreLoad;
      dur_d    = dur_load(start_cls);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q    <= 1'b0;
      wall_q   <= 1'b0;
      goal_q   <= 1'b0;
      state_q  <= StIdle;
      active_q <= ClsNone;
      tone_q   <= 1'b0;
      pend_q   <= 3'b000;
      half_q   <= '0;
      pre_q    <= '0;
      dur_q    <= '0;
    end else begin
      hit_q    <= hit;
      wall_q   <= wall;
      goal_q   <= goal;
      state_q  <= state_d;
      active_q <= active_d;
      tone_q   <= tone_d;
      pend_q   <= pend_d;
      half_q   <= half_d;
      pre_q    <= pre_d;
      dur_q    <= dur_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign active = active_q;
  assign sound  = tone_q & ~mute;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: vector table, directed corner sequences and random stimulus,
// all checked against a burst-level reference model.
module tb_sfx_scheduler;

  localparam int unsigned TickDiv  = 10;
  localparam int unsigned HitHalf  = 3;
  localparam int unsigned WallHalf = 5;
  localparam int unsigned GoalHalf = 2;
  localparam int unsigned HitMs    = 4;
  localparam int unsigned WallMs   = 3;
  localparam int unsigned GoalMs   = 6;
  localparam int unsigned GapMs    = 2;

  logic       clk = 1'b0;
  logic       rst, hit, wall, goal, mute;
  logic       sound, busy;
  logic [1:0] active;

  sfx_scheduler #(
    .TICK_DIV (TickDiv),
    .HIT_HALF (HitHalf),
    .WALL_HALF(WallHalf),
    .GOAL_HALF(GoalHalf),
    .HIT_MS   (HitMs),
    .WALL_MS  (WallMs),
    .GOAL_MS  (GoalMs),
    .GAP_MS   (GapMs)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .hit   (hit),
    .wall  (wall),
    .goal  (goal),
    .mute  (mute),
    .sound (sound),
    .busy  (busy),
    .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: mode 0=idle 1=play 2=gap, elapsed cycles in mode, mode length in cycles.
  int       m_mode, m_cls, m_el, m_len;
  bit [3:1] m_pend, m_prev;

  int cnt_act[0:3];
  int first_act[0:3];
  int last_act[0:3];
  int cnt_gap;

  function automatic int ms_of(input int c);
    case (c)
      1: return HitMs;
      2: return WallMs;
      3: return GoalMs;
      default: return 0;
    endcase
  endfunction

  function automatic int half_of(input int c);
    case (c)
      1: return HitHalf;
      2: return WallHalf;
      3: return GoalHalf;
      default: return 1;
    endcase
  endfunction

  task automatic model_start(input int k, input bit [3:1] rq);
    m_pend    = m_pend | rq;
    m_pend[k] = 1'b0;
    if (k == 3) m_pend[2:1] = 2'b00;
    m_mode = 1;
    m_cls  = k;
    m_el   = 0;
    m_len  = ms_of(k) * TickDiv;
  endtask

  task automatic model_step(input bit h, input bit w, input bit g, input bit r);
    bit [3:1] in_v, rq;
    int       top, cand;
    if (r) begin
      m_mode = 0; m_cls = 0; m_el = 0; m_len = 0; m_pend = '0; m_prev = '0;
      return;
    end
    in_v   = {g, w, h};
    rq     = in_v & ~m_prev;
    m_prev = in_v;
    top    = rq[3] ? 3 : rq[2] ? 2 : rq[1] ? 1 : 0;
    case (m_mode)
      0: begin
        cand = (m_pend[3] | rq[3]) ? 3 : (m_pend[2] | rq[2]) ? 2 : (m_pend[1] | rq[1]) ? 1 : 0;
        if (cand != 0) model_start(cand, rq);
      end
      1: begin
        if (top > m_cls) begin
          model_start(top, rq);
        end else begin
          for (int k = 1; k <= 3; k++) if (rq[k] && k != m_cls) m_pend[k] = 1'b1;
          if (rq[m_cls]) begin
            m_el = 0;
          end else begin
            m_el++;
            if (m_el == m_len) begin
              m_cls = 0;
              m_el  = 0;
              if (m_pend != 0) begin
                m_mode = 2;
                m_len  = GapMs * TickDiv;
              end else begin
                m_mode = 0;
              end
            end
          end
        end
      end
      default: begin
        if (rq[3]) begin
          model_start(3, rq);
        end else begin
          m_pend = m_pend | rq;
          m_el++;
          if (m_el == m_len) begin
            m_mode = 0;
            m_el   = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic clear_meas();
    cyc = 0;
    cnt_gap = 0;
    for (int i = 0; i < 4; i++) begin
      cnt_act[i] = 0; first_act[i] = -1; last_act[i] = -1;
    end
  endtask

  // One clock: drive, let the model advance at the edge, compare on the falling edge.
  task automatic step(input bit h, input bit w, input bit g, input bit m, input bit r);
    bit       e_s, e_b;
    bit [1:0] e_a;
    hit = h; wall = w; goal = g; mute = m; rst = r;
    @(posedge clk);
    model_step(h, w, g, r);
    @(negedge clk);
    cyc++;
    e_b = (m_mode != 0);
    e_a = (m_mode == 1) ? 2'(m_cls) : 2'd0;
    e_s = (m_mode == 1) && (((m_el / half_of(m_cls)) % 2) == 1) && !m;
    check("model_sound", sound, e_s);
    check("model_busy", busy, e_b);
    check("model_active", active, e_a);
    if (active != 2'd0) begin
      cnt_act[active]++;
      if (first_act[active] < 0) first_act[active] = cyc;
      last_act[active] = cyc;
    end
    if (busy && active == 2'd0) cnt_gap++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit       h, w, g, m, r;
    int       reps;
    bit       s, b;
    bit [1:0] a;
  } vec_t;

  function automatic vec_t mk(input bit h, input bit w, input bit g, input bit m, input bit r,
                              input int reps, input bit s, input bit b, input bit [1:0] a);
    vec_t v;
    v.h = h; v.w = w; v.g = g; v.m = m; v.r = r; v.reps = reps; v.s = s; v.b = b; v.a = a;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit rh, rw, rg, rm, rr;

    // Single hit burst: toggles every 3 cycles, cycles 1..40 active.
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 1));
    for (int i = 0; i < 12; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 3, (i % 2) == 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0));
    // Muted goal burst: 60 cycles active, sound held low.
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 59, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0));

    clear_meas();
    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        step(tbl[i].h, tbl[i].w, tbl[i].g, tbl[i].m, tbl[i].r);
        check($sformatf("tbl%0d_sound", i), sound, tbl[i].s);
        check($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
        check($sformatf("tbl%0d_active", i), active, tbl[i].a);
      end
    end

    // Pend then gap: wall at 0, hit at 5.
    step(0, 0, 0, 0, 1); clear_meas();
    step(0, 1, 0, 0, 0); idle(4); step(1, 0, 0, 0, 0); idle(100);
    check("pend_wall_first", first_act[2], 1);
    check("pend_wall_len", cnt_act[2], 30);
    check("pend_gap_len", cnt_gap, 20);
    check("pend_hit_first", first_act[1], 52);
    check("pend_hit_len", cnt_act[1], 40);
    check("pend_end_busy", busy, 0);

    // Preempt chain, goal clears stale rally sounds.
    step(0, 0, 0, 0, 1); clear_meas();
    step(1, 0, 0, 0, 0); idle(7); step(0, 1, 0, 0, 0); idle(3); step(0, 0, 1, 0, 0); idle(80);
    check("pre_hit_len", cnt_act[1], 8);
    check("pre_wall_len", cnt_act[2], 4);
    check("pre_goal_first", first_act[3], 13);
    check("pre_goal_len", cnt_act[3], 60);
    check("pre_goal_last", last_act[3], 72);
    check("pre_no_gap", cnt_gap, 0);
    check("pre_end_busy", busy, 0);

    // Held level gives one burst.
    step(0, 0, 0, 0, 1); clear_meas();
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0);
    idle(5);
    check("held_hit_len", cnt_act[1], 40);
    check("held_hit_first", first_act[1], 1);

    // Retrigger at cycle 20 extends the burst to cycle 60.
    step(0, 0, 0, 0, 1); clear_meas();
    step(1, 0, 0, 0, 0); idle(19); step(1, 0, 0, 0, 0); idle(60);
    check("retrig_last", last_act[1], 60);
    check("retrig_len", cnt_act[1], 60);
    check("retrig_no_gap", cnt_gap, 0);

    // Simultaneous hit+wall.
    step(0, 0, 0, 0, 1); clear_meas();
    step(1, 1, 0, 0, 0); idle(100);
    check("sim_wall_first", first_act[2], 1);
    check("sim_gap_len", cnt_gap, 20);
    check("sim_hit_first", first_act[1], 52);
    check("sim_hit_len", cnt_act[1], 40);

    // Reset mid-wall drops the pending hit.
    step(0, 0, 0, 0, 1); clear_meas();
    step(1, 1, 0, 0, 0); idle(9); step(0, 0, 0, 0, 1);
    check("rst_sound", sound, 0);
    check("rst_busy", busy, 0);
    check("rst_active", active, 0);
    idle(80);
    check("rst_wall_len", cnt_act[2], 10);
    check("rst_no_hit", cnt_act[1], 0);

    // Random stimulus against the model.
    step(0, 0, 0, 0, 1); clear_meas();
    rh = 0; rw = 0; rg = 0; rm = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 24) == 0) rh = ~rh;
      if ($urandom_range(0, 29) == 0) rw = ~rw;
      if ($urandom_range(0, 59) == 0) rg = ~rg;
      if ($urandom_range(0, 39) == 0) rm = ~rm;
      rr = ($urandom_range(0, 799) == 0);
      step(rh, rw, rg, rm, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
